// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared constants and types for the pipeline hazard controller
//
// Purpose: stall-bus width, pipeline stage indices and flush FSM state
//          encodings shared by pipe_hazard_ctrl and its mask generator.
// Ports:   none (package).
package pipe_hazard_ctrl_pkg;

  // Default stall bus width: PC plus the five stage registers.
  localparam int STALL_W = 6;

  // Stage indices; bit k of the stall vector freezes stage k.
  localparam int STG_PC  = 0;
  localparam int STG_IF  = 1;
  localparam int STG_ID  = 2;
  localparam int STG_EX  = 3;
  localparam int STG_MEM = 4;
  localparam int STG_WB  = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } flush_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_stall_mask_gen.sv
// rtl/pipe_hazard_ctrl_stall_mask_gen.sv - stage index to thermometer stall mask
//
// Purpose: converts one stall source's stage index into the mask of that
//          stage and every stage upstream of it (bits [stage:0]).
// Ports:   req   - source is requesting a stall
//          stage - stage index the source is bound to
//          mask  - thermometer mask, all zero when req=0
module pipe_hazard_ctrl_stall_mask_gen
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int NSTAGE = STALL_W,
  parameter int SW     = $clog2(NSTAGE)
) (
  input  logic              req,
  input  logic [SW-1:0]     stage,
  output logic [NSTAGE-1:0] mask
);

  always_comb begin
    int deep;
    // An out-of-range stage index stalls the whole pipe rather than nothing.
    deep = (int'(stage) >= NSTAGE) ? NSTAGE - 1 : int'(stage);
    mask = '0;
    for (int k = 0; k < NSTAGE; k++) begin
      mask[k] = req && (k <= deep);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - parametrised stall/flush controller for the in-order pipeline
//
// Purpose: merges per-source stall requests into one stall vector, sequences
//          registered flushes with a redirect PC, and raises a watchdog pulse
//          after MAX_STALL consecutive stall cycles.
// Ports:   clk           - pipeline clock
//          rst           - asynchronous active-low reset
//          stallreq      - per-source level stall requests
//          flush_req     - single-cycle flush request
//          flush_pc      - redirect target, valid with flush_req
//          stall         - stall vector (bit 0 = PC, bit k = stage k)
//          flush         - flush all stage registers
//          new_pc        - redirect PC, valid while flush=1
//          stall_timeout - one-cycle watchdog pulse
//          stall_cycles  - cycles with stall!=0 (only with STALL_PERF_EN)
//          flush_count   - accepted flush requests (only with STALL_PERF_EN)
// Config:  STALL_PERF_EN adds the two performance counters and their ports.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int NSTAGE = STALL_W,
  parameter int NREQ   = 2,
  localparam int SW    = $clog2(NSTAGE),
  parameter logic [NREQ*SW-1:0] REQ_STAGE = {3'd3, 3'd2},
  parameter int FLUSH_LEN = 1,
  parameter int MAX_STALL = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   stallreq,
  input  logic              flush_req,
  input  logic [31:0]       flush_pc,
  output logic [NSTAGE-1:0] stall,
  output logic              flush,
  output logic [31:0]       new_pc,
  output logic              stall_timeout
`ifdef STALL_PERF_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [15:0]       flush_count
`endif
);

  localparam int CW = $clog2(MAX_STALL + 1);

  // ---------------- stall merge ----------------
  logic [NSTAGE-1:0] req_mask [NREQ];
  logic [NSTAGE-1:0] merged;

  for (genvar i = 0; i < NREQ; i++) begin : g_src
    pipe_hazard_ctrl_stall_mask_gen #(
      .NSTAGE (NSTAGE),
      .SW     (SW)
    ) u_mask (
      .req   (stallreq[i]),
      .stage (REQ_STAGE[i*SW +: SW]),
      .mask  (req_mask[i])
    );
  end

  // OR of thermometer masks equals the mask of the deepest requester.
  always_comb begin
    merged = '0;
    for (int i = 0; i < NREQ; i++) begin
      merged = merged | req_mask[i];
    end
  end

  // ---------------- flush FSM ----------------
  flush_state_e state, state_nxt;
  logic [3:0]   flush_cnt, flush_cnt_nxt;
  logic [31:0]  new_pc_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      flush_cnt <= '0;
      new_pc    <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
      new_pc    <= new_pc_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    new_pc_nxt    = new_pc;
    // A new request always reloads, so the newest redirect wins mid-flush.
    if (flush_req) begin
      state_nxt     = FLUSH;
      flush_cnt_nxt = 4'(FLUSH_LEN - 1);
      new_pc_nxt    = flush_pc;
    end else if (state == FLUSH) begin
      if (flush_cnt == '0) begin
        state_nxt = IDLE;
      end else begin
        flush_cnt_nxt = flush_cnt - 4'd1;
      end
    end
  end

  assign flush = (state == FLUSH);

  // Flush dominates stall; reset also holds the stall vector low.
  assign stall = (rst && !flush) ? merged : '0;

  // ---------------- watchdog ----------------
  logic [CW-1:0] stall_cnt;
  logic          stall_any;

  assign stall_any = (stall != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt     <= '0;
      stall_timeout <= 1'b0;
    end else begin
      if (!stall_any) begin
        stall_cnt <= '0;
      end else if (stall_cnt != CW'(MAX_STALL)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      // Fires on the edge where the count first lands on MAX_STALL; the
      // saturated count can never pass through MAX_STALL-1 again until cleared.
      stall_timeout <= stall_any && (stall_cnt == CW'(MAX_STALL - 1));
    end
  end

`ifdef STALL_PERF_EN
  // ---------------- performance counters ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall_any) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (flush_req) begin
        flush_count <= flush_count + 16'd1;
      end
    end
  end
`endif

endmodule
